// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 initiator: one INCR burst per command, one status word back.
// Optional 4 KB boundary rejection is enabled by defining AXI4_BURST_MASTER_4K_CHECK_EN.
module axi4_burst_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int ID_WIDTH   = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [ID_WIDTH-1:0]   cmd_id,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_WIDTH-1:0] wr_strb,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_last,
   output logic                  rd_valid,
   input  logic                  rd_ready,
   output logic [1:0]            sts_resp,
   output logic                  sts_valid,
   input  logic                  sts_ready,
   output logic [ID_WIDTH-1:0]   m_axi_awid,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic [7:0]            m_axi_awlen,
   output logic [2:0]            m_axi_awsize,
   output logic [1:0]            m_axi_awburst,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [DATA_WIDTH-1:0] m_axi_wdata,
   output logic [STRB_WIDTH-1:0] m_axi_wstrb,
   output logic                  m_axi_wlast,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [ID_WIDTH-1:0]   m_axi_bid,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic [ID_WIDTH-1:0]   m_axi_arid,
   output logic [ADDR_WIDTH-1:0] m_axi_araddr,
   output logic [7:0]            m_axi_arlen,
   output logic [2:0]            m_axi_arsize,
   output logic [1:0]            m_axi_arburst,
   output logic                  m_axi_arvalid,
   input  logic                  m_axi_arready,
   input  logic [ID_WIDTH-1:0]   m_axi_rid,
   input  logic [DATA_WIDTH-1:0] m_axi_rdata,
   input  logic [1:0]            m_axi_rresp,
   input  logic                  m_axi_rlast,
   input  logic                  m_axi_rvalid,
   output logic                  m_axi_rready
);

   // state     | meaning
   // S_IDLE    | waiting for a command, cmd_ready high
   // S_WRITE   | AW and W channels running concurrently (or discarding beats)
   // S_WR_RESP | waiting for the B response
   // S_RD_ADDR | AR presented until accepted
   // S_RD_DATA | R beats passed through to rd_*
   // S_STATUS  | status word presented until accepted
   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_STATUS
   } state_t;

   localparam logic [2:0] AXSIZE = 3'($clog2(STRB_WIDTH));

   state_t                r_state;
   logic                  r_cmd_ready, r_awvalid, r_arvalid, r_bready, r_sts_valid;
   logic                  r_aw_done, r_w_done, r_drop, r_err_seen;
   logic [7:0]            r_beat_cnt, r_len;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ID_WIDTH-1:0]   r_id;
   logic [1:0]            r_sts_resp;

   logic w_w_active, w_last_beat, w_w_hs, w_aw_fin, w_w_fin, w_r_active, w_r_hs, w_cross;
   logic w_unused_rid;

   assign w_w_active  = (r_state == S_WRITE) && !r_w_done;
   assign w_last_beat = (r_beat_cnt == r_len);
   assign w_r_active  = (r_state == S_RD_DATA);

   // Discarded bursts still drain the beat stream but never reach the W channel.
   assign m_axi_wvalid = w_w_active && !r_drop && wr_valid;
   assign wr_ready     = w_w_active && (r_drop || m_axi_wready);
   assign m_axi_wdata  = wr_data;
   assign m_axi_wstrb  = wr_strb;
   assign m_axi_wlast  = w_w_active && w_last_beat;
   assign w_w_hs       = w_w_active && wr_valid && wr_ready;
   assign w_aw_fin     = r_aw_done || (r_awvalid && m_axi_awready);
   assign w_w_fin      = r_w_done || (w_w_hs && w_last_beat);

   assign rd_valid     = w_r_active && m_axi_rvalid;
   assign m_axi_rready = w_r_active && rd_ready;
   assign rd_data      = m_axi_rdata;
   assign rd_last      = w_r_active && m_axi_rlast;
   assign w_r_hs       = w_r_active && m_axi_rvalid && rd_ready;
   assign w_unused_rid = ^m_axi_rid;

`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
   logic [31:0] w_end;
   assign w_end   = 32'(cmd_addr[11:0]) + (32'(cmd_len) + 32'd1) * 32'(STRB_WIDTH);
   assign w_cross = (w_end > 32'd4096);
`else
   assign w_cross = 1'b0;
`endif

   assign cmd_ready     = r_cmd_ready;
   assign sts_valid     = r_sts_valid;
   assign sts_resp      = r_sts_resp;
   assign m_axi_bready  = r_bready;
   assign m_axi_awvalid = r_awvalid;
   assign m_axi_awid    = r_id;
   assign m_axi_awaddr  = r_addr;
   assign m_axi_awlen   = r_len;
   assign m_axi_awsize  = AXSIZE;
   assign m_axi_awburst = 2'b01;
   assign m_axi_arvalid = r_arvalid;
   assign m_axi_arid    = r_id;
   assign m_axi_araddr  = r_addr;
   assign m_axi_arlen   = r_len;
   assign m_axi_arsize  = AXSIZE;
   assign m_axi_arburst = 2'b01;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b0;
         r_awvalid   <= 1'b0;
         r_arvalid   <= 1'b0;
         r_bready    <= 1'b0;
         r_sts_valid <= 1'b0;
         r_aw_done   <= 1'b0;
         r_w_done    <= 1'b0;
         r_drop      <= 1'b0;
         r_err_seen  <= 1'b0;
         r_beat_cnt  <= '0;
         r_len       <= '0;
         r_addr      <= '0;
         r_id        <= '0;
         r_sts_resp  <= 2'b00;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_cmd_ready && cmd_valid) begin
                  r_cmd_ready <= 1'b0;
                  r_addr      <= cmd_addr;
                  r_len       <= cmd_len;
                  r_id        <= cmd_id;
                  r_beat_cnt  <= '0;
                  r_sts_resp  <= 2'b00;
                  r_err_seen  <= 1'b0;
                  r_aw_done   <= 1'b0;
                  r_w_done    <= 1'b0;
                  r_drop      <= 1'b0;
                  if (w_cross) begin
                     if (cmd_write) begin
                        r_state   <= S_WRITE;
                        r_drop    <= 1'b1;
                        r_aw_done <= 1'b1;
                     end else begin
                        r_state     <= S_STATUS;
                        r_sts_resp  <= 2'b10;
                        r_sts_valid <= 1'b1;
                     end
                  end else if (cmd_write) begin
                     r_state   <= S_WRITE;
                     r_awvalid <= 1'b1;
                  end else begin
                     r_state   <= S_RD_ADDR;
                     r_arvalid <= 1'b1;
                  end
               end else begin
                  r_cmd_ready <= 1'b1;
               end
            end
            S_WRITE: begin
               if (r_awvalid && m_axi_awready) begin
                  r_awvalid <= 1'b0;
                  r_aw_done <= 1'b1;
               end
               if (w_w_hs) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
                  if (w_last_beat) r_w_done <= 1'b1;
               end
               if (w_aw_fin && w_w_fin) begin
                  if (r_drop) begin
                     r_state     <= S_STATUS;
                     r_sts_resp  <= 2'b10;
                     r_sts_valid <= 1'b1;
                  end else begin
                     r_state  <= S_WR_RESP;
                     r_bready <= 1'b1;
                  end
               end
            end
            S_WR_RESP: begin
               if (m_axi_bvalid) begin
                  r_bready    <= 1'b0;
                  r_sts_resp  <= (m_axi_bid != r_id) ? 2'b10 : m_axi_bresp;
                  r_sts_valid <= 1'b1;
                  r_state     <= S_STATUS;
               end
            end
            S_RD_ADDR: begin
               if (m_axi_arready) begin
                  r_arvalid <= 1'b0;
                  r_state   <= S_RD_DATA;
               end
            end
            S_RD_DATA: begin
               if (w_r_hs) begin
                  r_beat_cnt <= r_beat_cnt + 8'd1;
                  if ((m_axi_rresp != 2'b00) && !r_err_seen) begin
                     r_sts_resp <= m_axi_rresp;
                     r_err_seen <= 1'b1;
                  end
                  // A short burst overrides any slave error code.
                  if (m_axi_rlast) begin
                     r_state     <= S_STATUS;
                     r_sts_valid <= 1'b1;
                     if (!w_last_beat) r_sts_resp <= 2'b10;
                  end
               end
            end
            S_STATUS: begin
               if (sts_ready) begin
                  r_sts_valid <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Directed bench for axi4_burst_master with a small behavioural AXI memory slave
// (0x4000-0x7FFF mapped, everything else answers DECERR).
module tb_axi4_burst_master;

   logic        clk, rstn;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [7:0]  cmd_id;
   logic [31:0] wr_data;
   logic [3:0]  wr_strb;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_last, rd_valid, rd_ready;
   logic [1:0]  sts_resp;
   logic        sts_valid, sts_ready;
   logic [7:0]  m_axi_awid, m_axi_arid, m_axi_bid, m_axi_rid;
   logic [31:0] m_axi_awaddr, m_axi_araddr, m_axi_wdata, m_axi_rdata;
   logic [7:0]  m_axi_awlen, m_axi_arlen;
   logic [2:0]  m_axi_awsize, m_axi_arsize;
   logic [1:0]  m_axi_awburst, m_axi_arburst, m_axi_bresp, m_axi_rresp;
   logic        m_axi_awvalid, m_axi_awready, m_axi_wlast, m_axi_wvalid, m_axi_wready;
   logic [3:0]  m_axi_wstrb;
   logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
   logic        m_axi_rlast, m_axi_rvalid, m_axi_rready;

   int checks = 0;
   int errors = 0;

   axi4_burst_master dut (
      .clk(clk), .rstn(rstn),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_id(cmd_id),
      .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .sts_resp(sts_resp), .sts_valid(sts_valid), .sts_ready(sts_ready),
      .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
      .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
      .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
      .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
      .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
      .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
      .m_axi_bready(m_axi_bready),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural slave ----------------
   logic [31:0] mem [0:4095];
   logic [31:0] wq [$];
   logic [31:0] rq [$];
   int          n_aw = 0, n_w = 0, n_wlast = 0, n_ar = 0, n_rdlast = 0, viol = 0;
   logic [31:0] s_awaddr, s_raddr, w_ra;
   logic [7:0]  s_awlen, s_awid, s_rlen, s_rcnt, s_rid;
   logic        s_aw_got, s_w_got, s_ract;
   logic        hold_aw = 1'b0, bid_corrupt = 1'b0;

   function automatic logic is_mapped(input logic [31:0] a);
      return (a >= 32'h4000) && (a < 32'h8000);
   endfunction

   function automatic logic [11:0] widx(input logic [31:0] a);
      logic [31:0] t;
      t = (a - 32'h4000) >> 2;
      return t[11:0];
   endfunction

   function automatic logic [1:0] wr_resp_of(input logic [31:0] a, input int n);
      for (int k = 0; k < n; k++)
         if (!is_mapped(a + 32'(k) * 4)) return 2'b11;
      return 2'b00;
   endfunction

   assign m_axi_awready = !hold_aw;
   assign m_axi_wready  = 1'b1;
   assign m_axi_arready = !s_ract;
   assign m_axi_rvalid  = s_ract;
   assign w_ra          = s_raddr + 32'(s_rcnt) * 4;
   assign m_axi_rdata   = is_mapped(w_ra) ? mem[widx(w_ra)] : 32'hDEADBEEF;
   assign m_axi_rresp   = is_mapped(w_ra) ? 2'b00 : 2'b11;
   assign m_axi_rlast   = (s_rcnt == s_rlen);
   assign m_axi_rid     = s_rid;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         s_aw_got     <= 1'b0;
         s_w_got      <= 1'b0;
         s_ract       <= 1'b0;
         s_rcnt       <= 8'd0;
         s_rlen       <= 8'd0;
         s_rid        <= 8'd0;
         s_raddr      <= 32'd0;
         m_axi_bvalid <= 1'b0;
         m_axi_bid    <= 8'd0;
         m_axi_bresp  <= 2'b00;
         wq.delete();
      end else begin
         if (m_axi_awvalid && m_axi_awready) begin
            s_awaddr <= m_axi_awaddr;
            s_awlen  <= m_axi_awlen;
            s_awid   <= m_axi_awid;
            s_aw_got <= 1'b1;
            n_aw     <= n_aw + 1;
         end
         if (m_axi_wvalid && m_axi_wready) begin
            wq.push_back(m_axi_wdata);
            n_w <= n_w + 1;
            if (m_axi_wlast) begin
               n_wlast <= n_wlast + 1;
               s_w_got <= 1'b1;
            end
         end
         if (s_aw_got && s_w_got && !m_axi_bvalid) begin
            for (int k = 0; k < wq.size(); k++)
               if (is_mapped(s_awaddr + 32'(k) * 4)) mem[widx(s_awaddr + 32'(k) * 4)] <= wq[k];
            m_axi_bresp  <= wr_resp_of(s_awaddr, wq.size());
            m_axi_bid    <= s_awid ^ {7'd0, bid_corrupt};
            m_axi_bvalid <= 1'b1;
            s_aw_got     <= 1'b0;
            s_w_got      <= 1'b0;
            wq.delete();
         end
         if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
         if (m_axi_arvalid && m_axi_arready) begin
            s_raddr <= m_axi_araddr;
            s_rlen  <= m_axi_arlen;
            s_rid   <= m_axi_arid;
            s_rcnt  <= 8'd0;
            s_ract  <= 1'b1;
            n_ar    <= n_ar + 1;
         end
         if (m_axi_rvalid && m_axi_rready) begin
            if (m_axi_rlast) s_ract <= 1'b0;
            else s_rcnt <= s_rcnt + 8'd1;
         end
      end
   end

   // Read-stream collector and valid-stability monitor.
   logic        p_awv = 1'b0, p_arv = 1'b0, p_rdv = 1'b0, p_stsv = 1'b0;
   logic [31:0] p_rdd = 32'd0;
   always @(posedge clk) begin
      if (rstn && rd_valid && rd_ready) begin
         rq.push_back(rd_data);
         if (rd_last) n_rdlast <= n_rdlast + 1;
      end
      if (rstn && ((p_awv && !m_axi_awvalid) || (p_arv && !m_axi_arvalid) ||
                   (p_stsv && !sts_valid) || (p_rdv && (!rd_valid || rd_data !== p_rdd))))
         viol <= viol + 1;
      p_awv  <= rstn && m_axi_awvalid && !m_axi_awready;
      p_arv  <= rstn && m_axi_arvalid && !m_axi_arready;
      p_stsv <= rstn && sts_valid && !sts_ready;
      p_rdv  <= rstn && rd_valid && !rd_ready;
      p_rdd  <= rd_data;
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
      int g;
      g = 0;
      @(negedge clk);
      while (!cmd_ready && g < 300) begin
         @(negedge clk);
         g++;
      end
      if (!cmd_ready) begin
         checks++; errors++;
         $display("FAIL cmd_ready_timeout: cmd_ready=%b required 1", cmd_ready);
      end
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = 8'h5A;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic send_beats(input int n, input logic [31:0] base, input logic [31:0] step,
                             input logic toggle);
      int   i, g;
      logic gap;
      i = 0; g = 0; gap = 1'b0;
      while (i < n && g < 5000) begin
         @(negedge clk);
         g++;
         if (gap) begin
            wr_valid = 1'b0;
            gap = 1'b0;
         end else begin
            wr_valid = 1'b1;
            wr_data  = base + 32'(i) * step;
            wr_strb  = 4'hF;
            #1;
            if (wr_ready) begin
               i++;
               gap = toggle;
            end
         end
      end
      @(negedge clk);
      wr_valid = 1'b0;
      if (i < n) begin
         checks++; errors++;
         $display("FAIL beat_timeout: sent %0d beats required %0d", i, n);
      end
   endtask

   task automatic wait_sts(output logic [1:0] resp);
      int g;
      g = 0;
      while (!sts_valid && g < 3000) begin
         @(negedge clk);
         g++;
      end
      if (!sts_valid) begin
         checks++; errors++;
         $display("FAIL sts_timeout: sts_valid=%b required 1", sts_valid);
         resp = 2'bxx;
      end else begin
         resp = sts_resp;
         @(negedge clk);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if ({cmd_ready, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, wr_ready, rd_valid,
           sts_valid, m_axi_bready, m_axi_rready} !== 9'd0) begin
         errors++;
         $display("FAIL reset_valids: got %b required 0", {cmd_ready, m_axi_awvalid,
                  m_axi_arvalid, m_axi_wvalid, wr_ready, rd_valid, sts_valid, m_axi_bready,
                  m_axi_rready});
      end
      checks++;
      if ({sts_resp, m_axi_awaddr, m_axi_awlen, m_axi_araddr} !== 74'd0) begin
         errors++;
         $display("FAIL reset_fields: sts_resp=%b awaddr=%h awlen=%h required 0",
                  sts_resp, m_axi_awaddr, m_axi_awlen);
      end
      checks++;
      if (m_axi_awsize !== 3'd2 || m_axi_arburst !== 2'b01) begin
         errors++;
         $display("FAIL axsize_burst: size=%0d burst=%b required 2/01", m_axi_awsize, m_axi_arburst);
      end
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL cmd_ready_pre_edge: got %b required 0", cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL cmd_ready_post_edge: got %b required 1", cmd_ready);
      end
   endtask

   task automatic test_write_read();
      int         a0, w0, wl0, r0;
      logic [1:0] resp;
      a0 = n_aw; w0 = n_w; wl0 = n_wlast;
      send_cmd(1'b1, 32'h4000, 8'd3);
      checks++;
      if (m_axi_awvalid !== 1'b1) begin
         errors++;
         $display("FAIL awvalid_latency: got %b required 1", m_axi_awvalid);
      end
      send_beats(4, 32'h11111111, 32'h11111111, 1'b0);
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL wr_status: got %b required 00", resp); end
      checks++;
      if (n_aw - a0 != 1 || s_awlen !== 8'd3) begin
         errors++;
         $display("FAIL aw_count: aw=%0d awlen=%0d required 1/3", n_aw - a0, s_awlen);
      end
      checks++;
      if (n_w - w0 != 4 || n_wlast - wl0 != 1) begin
         errors++;
         $display("FAIL w_count: beats=%0d wlast=%0d required 4/1", n_w - w0, n_wlast - wl0);
      end
      rq.delete();
      r0 = n_rdlast;
      send_cmd(1'b0, 32'h4000, 8'd3);
      checks++;
      if (m_axi_arvalid !== 1'b1) begin
         errors++;
         $display("FAIL arvalid_latency: got %b required 1", m_axi_arvalid);
      end
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL rd_status: got %b required 00", resp); end
      checks++;
      if (rq.size() != 4 || n_rdlast - r0 != 1) begin
         errors++;
         $display("FAIL rd_count: beats=%0d rd_last=%0d required 4/1", rq.size(), n_rdlast - r0);
      end
      for (int i = 0; i < 4 && i < rq.size(); i++) begin
         checks++;
         if (rq[i] !== 32'h11111111 * 32'(i + 1)) begin
            errors++;
            $display("FAIL rd_data[%0d]: got %h required %h", i, rq[i], 32'h11111111 * 32'(i + 1));
         end
      end
   endtask

   task automatic test_stall();
      int          a0, g;
      logic [1:0]  resp;
      logic [31:0] d0;
      hold_aw = 1'b1;
      a0 = n_aw;
      send_cmd(1'b1, 32'h4000, 8'd3);
      send_beats(4, 32'hC0DE0001, 32'h00010001, 1'b1);
      #1;
      checks++;
      if (n_aw != a0 || m_axi_awvalid !== 1'b1 || wr_ready !== 1'b0) begin
         errors++;
         $display("FAIL w_before_aw: aw=%0d awvalid=%b wr_ready=%b required 0/1/0",
                  n_aw - a0, m_axi_awvalid, wr_ready);
      end
      hold_aw = 1'b0;
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL stall_wr_status: got %b required 00", resp); end
      rq.delete();
      send_cmd(1'b0, 32'h4000, 8'd3);
      g = 0;
      while (rq.size() < 2 && g < 100) begin
         @(negedge clk);
         g++;
      end
      rd_ready = 1'b0;
      #1;
      d0 = rd_data;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         checks++;
         if (rd_valid !== 1'b1 || rd_data !== d0) begin
            errors++;
            $display("FAIL rd_stall_hold: rd_valid=%b data=%h required 1/%h", rd_valid, rd_data, d0);
         end
      end
      rd_ready = 1'b1;
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00 || rq.size() != 4) begin
         errors++;
         $display("FAIL stall_rd: status=%b beats=%0d required 00/4", resp, rq.size());
      end
      for (int i = 0; i < 4 && i < rq.size(); i++) begin
         checks++;
         if (rq[i] !== 32'hC0DE0001 + 32'(i) * 32'h00010001) begin
            errors++;
            $display("FAIL stall_data[%0d]: got %h required %h", i, rq[i],
                     32'hC0DE0001 + 32'(i) * 32'h00010001);
         end
      end
   endtask

   task automatic test_long_burst();
      int         w0, wl0, r0, bad;
      logic [1:0] resp;
      w0 = n_w; wl0 = n_wlast;
      send_cmd(1'b1, 32'h4000, 8'd255);
      send_beats(256, 32'hA5000000, 32'd1, 1'b0);
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00 || n_w - w0 != 256 || n_wlast - wl0 != 1) begin
         errors++;
         $display("FAIL long_wr: status=%b beats=%0d wlast=%0d required 00/256/1",
                  resp, n_w - w0, n_wlast - wl0);
      end
      rq.delete();
      r0 = n_rdlast;
      send_cmd(1'b0, 32'h4000, 8'd255);
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00 || rq.size() != 256 || n_rdlast - r0 != 1) begin
         errors++;
         $display("FAIL long_rd: status=%b beats=%0d rd_last=%0d required 00/256/1",
                  resp, rq.size(), n_rdlast - r0);
      end
      bad = 0;
      for (int i = 0; i < rq.size(); i++)
         if (rq[i] !== 32'hA5000000 + 32'(i)) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL long_data: %0d wrong beats required 0", bad);
      end
   endtask

   task automatic test_decerr();
      logic [1:0] resp;
      send_cmd(1'b0, 32'h0000, 8'd0);
      wait_sts(resp);
      checks++;
      if (resp !== 2'b11) begin errors++; $display("FAIL decerr_status: got %b required 11", resp); end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL decerr_idle: cmd_ready=%b required 1", cmd_ready);
      end
   endtask

   task automatic test_bid_mismatch();
      logic [1:0] resp;
      bid_corrupt = 1'b1;
      send_cmd(1'b1, 32'h4100, 8'd0);
      send_beats(1, 32'h0000BEEF, 32'd0, 1'b0);
      wait_sts(resp);
      bid_corrupt = 1'b0;
      checks++;
      if (resp !== 2'b10) begin errors++; $display("FAIL bid_mismatch: got %b required 10", resp); end
   endtask

   task automatic test_4k();
      int         a0, w0, r0;
      logic [1:0] resp;
      a0 = n_aw; w0 = n_w;
      send_cmd(1'b1, 32'h4FF8, 8'd3);
      send_beats(4, 32'h77770000, 32'd1, 1'b0);
      wait_sts(resp);
`ifdef AXI4_BURST_MASTER_4K_CHECK_EN
      checks++;
      if (resp !== 2'b10 || n_aw != a0 || n_w != w0) begin
         errors++;
         $display("FAIL 4k_reject: status=%b aw=%0d w=%0d required 10/0/0", resp, n_aw - a0, n_w - w0);
      end
`else
      checks++;
      if (resp !== 2'b00 || n_aw - a0 != 1 || n_w - w0 != 4) begin
         errors++;
         $display("FAIL 4k_issue: status=%b aw=%0d w=%0d required 00/1/4", resp, n_aw - a0, n_w - w0);
      end
`endif
      r0 = n_ar;
      send_cmd(1'b0, 32'h4FF0, 8'd3);
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00 || n_ar - r0 != 1) begin
         errors++;
         $display("FAIL 4k_edge_read: status=%b ar=%0d required 00/1", resp, n_ar - r0);
      end
   endtask

   task automatic test_reset_mid_burst();
      logic [1:0] resp;
      send_cmd(1'b1, 32'h4000, 8'd7);
      wr_valid = 1'b1; wr_data = 32'h00000001; wr_strb = 4'hF;
      @(negedge clk);
      wr_data = 32'h00000002;
      #1;
      rstn = 1'b0;
      #1;
      checks++;
      if ({cmd_ready, m_axi_awvalid, m_axi_arvalid, m_axi_wvalid, wr_ready, rd_valid,
           sts_valid, m_axi_bready, m_axi_rready} !== 9'd0) begin
         errors++;
         $display("FAIL midreset_valids: got %b required 0", {cmd_ready, m_axi_awvalid,
                  m_axi_arvalid, m_axi_wvalid, wr_ready, rd_valid, sts_valid, m_axi_bready,
                  m_axi_rready});
      end
      wr_valid = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL midreset_ready_early: got %b required 0", cmd_ready);
      end
      @(negedge clk);
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL midreset_ready: got %b required 1", cmd_ready);
      end
      send_cmd(1'b1, 32'h4200, 8'd0);
      send_beats(1, 32'h12345678, 32'd0, 1'b0);
      wait_sts(resp);
      checks++;
      if (resp !== 2'b00) begin errors++; $display("FAIL post_reset_write: got %b required 00", resp); end
   endtask

   task automatic test_stability();
      checks++;
      if (viol != 0) begin
         errors++;
         $display("FAIL valid_stability: %0d drops required 0", viol);
      end
   endtask

   initial begin
      rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
      wr_data = '0; wr_strb = '0; wr_valid = 1'b0; rd_ready = 1'b1; sts_ready = 1'b1;
      test_reset();
      test_write_read();
      test_stall();
      test_long_burst();
      test_decerr();
      test_bid_mismatch();
      test_4k();
      test_reset_mid_burst();
      test_stability();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
